bin_to_bcd_seq: RTL and testbench

//  Sequential double-dabble converter between the signed multiplier datapath and the

---
 rtl/bin_to_bcd_seq.sv | 96 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: signed/unsigned BIN_W-bit value to sign flag plus
// DIGITS packed BCD digits. One shift per clock; bcd/neg update only together with done.
//
//   state | meaning
//   IDLE  | waiting for start, last result held on bcd/neg
//   SHIFT | add-3 then shift, BIN_W iterations
//   DONE  | publish scratch to bcd/neg, pulse done
module bin_to_bcd_seq #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  is_signed,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [BIN_W-1:0]    mag;
   logic [4*DIGITS-1:0] scratch;
   logic [4*DIGITS-1:0] adj;
   logic                neg_int;
   logic                neg_load;

   assign neg_load = is_signed & bin_in[BIN_W-1];

   // Add-3 correction is applied to every digit before the shift, never after.
   always_comb begin
      adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         mag     <= '0;
         scratch <= '0;
         neg_int <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         neg     <= 1'b0;
         bcd     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Negation modulo 2^BIN_W: the most negative value maps onto itself.
                  mag     <= neg_load ? (~bin_in + {{(BIN_W-1){1'b0}}, 1'b1}) : bin_in;
                  neg_int <= neg_load;
                  scratch <= '0;
                  cnt     <= CNT_W'(BIN_W);
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               {scratch, mag} <= {adj[4*DIGITS-2:0], mag, 1'b0};
               cnt            <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1))
                  state <= DONE;
            end
            DONE: begin
               bcd   <= scratch;
               neg   <= neg_int;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed corner cases plus random values
// compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [15:0] bin_in;
   logic        busy;
   logic        done;
   logic        neg;
   logic [19:0] bcd;

   int tests = 0;
   int fails = 0;
   logic [19:0] prev_bcd;
   logic        prev_neg;

   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .bin_in    (bin_in),
      .busy      (busy),
      .done      (done),
      .neg       (neg),
      .bcd       (bcd)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] ref_bcd(input logic [15:0] v, input bit sg);
      int m;
      logic [19:0] r;
      m = int'(v);
      if (sg && v[15]) m = 65536 - m;
      r = '0;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: inputs are sampled at the following posedge.
   task automatic launch(input logic [15:0] v, input bit sg);
      start = 1'b1;
      bin_in = v;
      is_signed = sg;
   endtask

   // Follows a conversion launched at the previous negedge until done, optionally
   // injecting ignored starts and/or chaining a new start in the done cycle.
   task automatic finish(input string tag, input logic [15:0] v, input bit sg,
                         input int ign_a, input int ign_b,
                         input bit chain, input logic [15:0] nv, input bit nsg);
      int edges = 0;
      int busy_n = 0;
      bit seen = 0;
      while (!seen && edges < 40) begin
         @(negedge clk);
         edges++;
         start = 1'b0;
         if (busy) busy_n++;
         if (edges == 1) begin
            chk({tag, " hold_bcd"}, 32'(bcd), 32'(prev_bcd));
            chk({tag, " hold_neg"}, 32'(neg), 32'(prev_neg));
            chk({tag, " done_low"}, 32'(done), 32'd0);
         end
         if (done) begin
            seen = 1;
            if (chain) launch(nv, nsg);
         end else if (edges == ign_a || edges == ign_b) begin
            start = 1'b1;
            bin_in = 16'h1234;
            is_signed = 1'b0;
         end
      end
      chk({tag, " latency"}, 32'(edges - 1), 32'd17);
      chk({tag, " bcd"}, 32'(bcd), 32'(ref_bcd(v, sg)));
      chk({tag, " neg"}, 32'(neg), 32'(sg && v[15]));
      chk({tag, " busy_cycles"}, 32'(busy_n), 32'd17);
      prev_bcd = ref_bcd(v, sg);
      prev_neg = sg && v[15];
   endtask

   task automatic quiet(input string tag, input int n);
      int pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) pulses++;
      end
      chk({tag, " no_done"}, 32'(pulses), 32'd0);
   endtask

   initial begin
      logic [15:0] rv;
      bit rs;
      rst = 1'b1;
      start = 1'b0;
      is_signed = 1'b0;
      bin_in = '0;
      prev_bcd = '0;
      prev_neg = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset neg", 32'(neg), 32'd0);
      chk("reset bcd", 32'(bcd), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      launch(16'h0000, 0); finish("u0000", 16'h0000, 0, 0, 0, 0, 0, 0);
      launch(16'hFFFF, 1); finish("sFFFF", 16'hFFFF, 1, 0, 0, 0, 0, 0);
      chk("sFFFF literal", 32'(bcd), 32'h00001);
      launch(16'hFF85, 1); finish("sFF85", 16'hFF85, 1, 0, 0, 0, 0, 0);
      chk("sFF85 literal", 32'(bcd), 32'h00123);
      launch(16'h8000, 1); finish("s8000", 16'h8000, 1, 0, 0, 0, 0, 0);
      chk("s8000 literal", 32'(bcd), 32'h32768);
      launch(16'hFFFF, 0); finish("uFFFF", 16'hFFFF, 0, 0, 0, 0, 0, 0);
      chk("uFFFF literal", 32'(bcd), 32'h65535);
      launch(16'h0000, 1); finish("s0000", 16'h0000, 1, 0, 0, 0, 0, 0);

      // starts while busy are dropped
      launch(16'h0007, 0); finish("ignore", 16'h0007, 0, 3, 10, 0, 0, 0);
      quiet("ignore", 20);
      chk("ignore bcd_after", 32'(bcd), 32'h00007);

      // reset in the middle of a conversion
      launch(16'h2710, 0);
      repeat (8) begin @(negedge clk); start = 1'b0; end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst bcd", 32'(bcd), 32'd0);
      chk("midrst neg", 32'(neg), 32'd0);
      prev_bcd = '0;
      prev_neg = 1'b0;
      quiet("midrst", 20);
      launch(16'h2710, 0); finish("after_rst", 16'h2710, 0, 0, 0, 0, 0, 0);
      chk("after_rst literal", 32'(bcd), 32'h10000);

      // back-to-back: second start in the done cycle
      launch(16'h0063, 0); finish("b2b_a", 16'h0063, 0, 0, 0, 1, 16'h0064, 0);
      chk("b2b_a literal", 32'(bcd), 32'h00099);
      finish("b2b_b", 16'h0064, 0, 0, 0, 0, 0, 0);
      chk("b2b_b literal", 32'(bcd), 32'h00100);

      for (int n = 0; n < 1000; n++) begin
         rv = 16'($urandom);
         rs = 1'($urandom);
         launch(rv, rs);
         finish("rand", rv, rs, 0, 0, 0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
